mem_port_arbiter: RTL and testbench

Shares a single memory port between the core's instruction-request and data-request channels, then routes in-order memory responses back to the instruction or data response channel. It sits between the core's `instReqQ`/`dataReqQ`/`instQ`/`dataQ` interfaces and the memory. It replaces the point-to-point wiring when instruction and data traffic go to one unified memory.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_tag_fifo.sv | 75 +++++++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// The field positions describe the default 32-bit address / 32-bit data request layout.
package mem_arb_pkg;

  localparam int WR_BIT   = 64;
  localparam int REQ_W    = 65;
  localparam int ADDR_HI  = 63;
  localparam int ADDR_LO  = 32;
  localparam int WDATA_HI = 31;
  localparam int WDATA_LO = 0;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_t;

endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// Circular buffer of 1-bit source tags, one per read still awaiting its memory response.
module tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  src_t       din_i,
  input  logic       pop_i,
  output src_t       head_o,
  output logic       empty_o,
  output logic       full_o,
  output logic [4:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + {{(PTR_W-1){1'b0}}, 1'b1};
  endfunction

  assign empty_o   = (count_q == 5'd0);
  assign full_o    = (count_q == 5'(DEPTH));
  assign count_o   = count_q;
  assign head_o    = src_t'(mem_q[rd_ptr_q]);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push_s = push_i && (!full_o || pop_i);
  assign do_pop_s  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= {DEPTH{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= 5'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one memory port between instruction and data requesters,
// with in-order response steering driven by a tag FIFO.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     inst_req_valid,
  input  logic [ADDR_W-1:0]        inst_req_addr,
  output logic                     inst_req_ready,
  output logic                     inst_resp_valid,
  output logic [DATA_W-1:0]        inst_resp_data,
  input  logic                     inst_resp_ready,
  input  logic                     data_req_valid,
  input  logic [ADDR_W+DATA_W:0]   data_req,
  output logic                     data_req_ready,
  output logic                     data_resp_valid,
  output logic [DATA_W-1:0]        data_resp_data,
  input  logic                     data_resp_ready,
  output logic                     mem_req_valid,
  output logic [ADDR_W+DATA_W:0]   mem_req,
  input  logic                     mem_req_ready,
  input  logic                     mem_resp_valid,
  input  logic [DATA_W-1:0]        mem_resp_data,
  output logic                     mem_resp_ready,
  output logic [4:0]               outstanding,
  output logic                     err_orphan_resp
);

  localparam int RW     = ADDR_W + DATA_W + 1;
  localparam int WR_POS = ADDR_W + DATA_W;

  logic          req_full_q, req_full_d;
  logic [RW-1:0] req_q, req_d;
  src_t          last_grant_q, last_grant_d;
  logic          err_q, err_d;

  src_t       head_s, push_tag_s;
  logic       empty_s, full_s, push_s, pop_s;
  logic [4:0] count_s;
  logic       below_max_s, data_wr_s, inst_elig_s, data_elig_s, can_load_s;
  logic       gnt_inst_s, gnt_data_s;

  tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push_s),
    .din_i   (push_tag_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .empty_o (empty_s),
    .full_o  (full_s),
    .count_o (count_s)
  );

  // Tag FIFO depth equals the read limit, so "not full" is the registered count below the limit.
  assign below_max_s = !full_s;
  assign data_wr_s   = data_req[WR_POS];
  assign inst_elig_s = inst_req_valid && below_max_s;
  assign data_elig_s = data_req_valid && (data_wr_s || below_max_s);
  assign can_load_s  = !req_full_q || mem_req_ready;

  always_comb begin
    gnt_inst_s = 1'b0;
    gnt_data_s = 1'b0;
    if (!can_load_s) begin
      gnt_inst_s = 1'b0;
    end else if (inst_elig_s && data_elig_s) begin
      gnt_inst_s = (last_grant_q == SRC_DATA);
      gnt_data_s = (last_grant_q == SRC_INST);
    end else begin
      gnt_inst_s = inst_elig_s;
      gnt_data_s = data_elig_s;
    end
  end

  assign inst_req_ready = gnt_inst_s;
  assign data_req_ready = gnt_data_s;
  assign push_s         = gnt_inst_s || (gnt_data_s && !data_wr_s);
  assign push_tag_s     = gnt_inst_s ? SRC_INST : SRC_DATA;

  always_comb begin
    req_full_d   = req_full_q;
    req_d        = req_q;
    last_grant_d = last_grant_q;
    if (gnt_inst_s) begin
      req_full_d   = 1'b1;
      req_d        = {1'b0, inst_req_addr, {DATA_W{1'b0}}};
      last_grant_d = SRC_INST;
    end else if (gnt_data_s) begin
      req_full_d   = 1'b1;
      req_d        = data_req;
      last_grant_d = SRC_DATA;
    end else if (req_full_q && mem_req_ready) begin
      req_full_d = 1'b0;
    end else begin
      req_full_d = req_full_q;
    end
  end

  // With nothing outstanding the port stays ready so a stray response is swallowed and flagged.
  always_comb begin
    inst_resp_valid = 1'b0;
    data_resp_valid = 1'b0;
    mem_resp_ready  = 1'b1;
    if (empty_s) begin
      mem_resp_ready = 1'b1;
    end else if (head_s == SRC_INST) begin
      inst_resp_valid = mem_resp_valid;
      mem_resp_ready  = inst_resp_ready;
    end else begin
      data_resp_valid = mem_resp_valid;
      mem_resp_ready  = data_resp_ready;
    end
  end

  assign pop_s  = mem_resp_valid && mem_resp_ready && !empty_s;
  assign err_d  = err_q || (mem_resp_valid && empty_s);

  assign inst_resp_data  = mem_resp_data;
  assign data_resp_data  = mem_resp_data;
  assign mem_req_valid   = req_full_q;
  assign mem_req         = req_q;
  assign outstanding     = count_s;
  assign err_orphan_resp = err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_full_q   <= 1'b0;
      req_q        <= {RW{1'b0}};
      last_grant_q <= SRC_DATA;
      err_q        <= 1'b0;
    end else begin
      req_full_q   <= req_full_d;
      req_q        <= req_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a per-cycle vector table plus hand sequences,
// with memory requests and core responses checked against scoreboard queues.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = AW + DW + 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          inst_req_valid, inst_req_ready, inst_resp_valid, inst_resp_ready;
  logic [AW-1:0] inst_req_addr;
  logic [DW-1:0] inst_resp_data, data_resp_data, mem_resp_data;
  logic          data_req_valid, data_req_ready, data_resp_valid, data_resp_ready;
  logic [RW-1:0] data_req, mem_req;
  logic          mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;
  logic [4:0]    outstanding;
  logic          err_orphan_resp;

  mem_port_arbiter #(.MAX_OUTSTANDING(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST),
    .inst_req_valid(inst_req_valid), .inst_req_addr(inst_req_addr), .inst_req_ready(inst_req_ready),
    .inst_resp_valid(inst_resp_valid), .inst_resp_data(inst_resp_data), .inst_resp_ready(inst_resp_ready),
    .data_req_valid(data_req_valid), .data_req(data_req), .data_req_ready(data_req_ready),
    .data_resp_valid(data_resp_valid), .data_resp_data(data_resp_data), .data_resp_ready(data_resp_ready),
    .mem_req_valid(mem_req_valid), .mem_req(mem_req), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_ready(mem_resp_ready),
    .outstanding(outstanding), .err_orphan_resp(err_orphan_resp)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [RW-1:0] exp_req_q[$];
  logic [DW:0]   exp_resp_q[$];

  localparam logic [RW-1:0] FETCH_REQ = {1'b0, 32'h0000_0100, 32'h0};

  typedef struct {
    logic iv, dv, dwr, mrr, rv, irr, drr;
    logic [DW-1:0] rdata;
    logic [10:0] expv; // {irdy, drdy, mqv, cnt[4:0], mresp_rdy, ivr, dvr}
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic [6:0] in, input logic [DW-1:0] rd, input logic [10:0] ex);
    vec_t v;
    {v.iv, v.dv, v.dwr, v.mrr, v.rv, v.irr, v.drr} = in;
    v.rdata = rd;
    v.expv  = ex;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic iv, input logic dv, input logic dwr, input logic mrr,
                       input logic rv, input logic irr, input logic drr, input logic [DW-1:0] rd);
    inst_req_valid  = iv;
    inst_req_addr   = 32'h0000_0100;
    data_req_valid  = dv;
    data_req        = {dwr, 32'h0000_0200, 32'h0000_0055};
    mem_req_ready   = mrr;
    mem_resp_valid  = rv;
    mem_resp_data   = rd;
    inst_resp_ready = irr;
    data_resp_ready = drr;
  endtask

  // Mid-cycle monitor: every handshake is matched against the next scoreboard entry.
  always @(negedge CLK) begin
    if (mem_req_valid && mem_req_ready) begin
      if (exp_req_q.size() == 0) chk("unexpected_mem_req", {63'd0, mem_req}, 128'd0);
      else chk("mem_req", {63'd0, mem_req}, {63'd0, exp_req_q.pop_front()});
    end
    if (inst_resp_valid && inst_resp_ready) begin
      if (exp_resp_q.size() == 0) chk("unexpected_inst_resp", {95'd0, 1'b0, inst_resp_data}, 128'd1);
      else chk("inst_resp", {95'd0, 1'b0, inst_resp_data}, {95'd0, exp_resp_q.pop_front()});
    end
    if (data_resp_valid && data_resp_ready) begin
      if (exp_resp_q.size() == 0) chk("unexpected_data_resp", {95'd0, 1'b1, data_resp_data}, 128'd0);
      else chk("data_resp", {95'd0, 1'b1, data_resp_data}, {95'd0, exp_resp_q.pop_front()});
    end
  end

  initial begin
    //                  iv dv wr mrr rv irr drr       data           irdy drdy mqv cnt  mrr ivr dvr
    tbl[0]  = mk(7'b1_0_0_1_0_1_1, 32'h0,    {3'b100, 5'd0, 3'b100});
    tbl[1]  = mk(7'b0_0_0_1_0_1_1, 32'h0,    {3'b001, 5'd1, 3'b100});
    tbl[2]  = mk(7'b0_0_0_1_1_1_1, 32'hDEAD, {3'b000, 5'd1, 3'b110});
    tbl[3]  = mk(7'b1_1_0_1_0_1_1, 32'h0,    {3'b010, 5'd0, 3'b100});
    tbl[4]  = mk(7'b1_1_0_1_0_1_1, 32'h0,    {3'b101, 5'd1, 3'b100});
    tbl[5]  = mk(7'b1_1_0_1_0_1_1, 32'h0,    {3'b011, 5'd2, 3'b100});
    tbl[6]  = mk(7'b1_1_0_1_0_1_1, 32'h0,    {3'b101, 5'd3, 3'b100});
    tbl[7]  = mk(7'b1_1_0_1_0_1_1, 32'h0,    {3'b001, 5'd4, 3'b100});
    tbl[8]  = mk(7'b1_1_1_1_0_1_1, 32'h0,    {3'b010, 5'd4, 3'b100});
    tbl[9]  = mk(7'b1_0_0_1_1_1_1, 32'h11,   {3'b001, 5'd4, 3'b101});
    tbl[10] = mk(7'b1_0_0_1_0_1_1, 32'h0,    {3'b100, 5'd3, 3'b100});
    tbl[11] = mk(7'b1_0_0_1_0_1_1, 32'h0,    {3'b001, 5'd4, 3'b100});
    tbl[12] = mk(7'b0_0_0_1_1_0_1, 32'h22,   {3'b000, 5'd4, 3'b010});
    tbl[13] = mk(7'b0_0_0_1_1_1_1, 32'h22,   {3'b000, 5'd4, 3'b110});
    tbl[14] = mk(7'b0_0_0_1_1_1_1, 32'h33,   {3'b000, 5'd3, 3'b101});
    tbl[15] = mk(7'b0_0_0_1_1_1_1, 32'h44,   {3'b000, 5'd2, 3'b110});
    tbl[16] = mk(7'b0_0_0_1_1_1_1, 32'h55,   {3'b000, 5'd1, 3'b110});
    tbl[17] = mk(7'b0_0_0_1_0_1_1, 32'h0,    {3'b000, 5'd0, 3'b100});

    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    step();
    step();
    chk("reset_state", {120'd0, mem_req_valid, outstanding, err_orphan_resp, inst_resp_valid},
        {120'd0, 1'b0, 5'd0, 1'b0, 1'b0});
    chk("reset_mem_req", {63'd0, mem_req}, 128'd0);
    RST = 1'b0;
    step();

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].iv, tbl[i].dv, tbl[i].dwr, tbl[i].mrr, tbl[i].rv, tbl[i].irr, tbl[i].drr, tbl[i].rdata);
      if (tbl[i].expv[10]) exp_req_q.push_back(FETCH_REQ);
      if (tbl[i].expv[9])  exp_req_q.push_back({tbl[i].dwr, 32'h0000_0200, 32'h0000_0055});
      if (tbl[i].rv && tbl[i].expv[2] && (tbl[i].expv[1] || tbl[i].expv[0]))
        exp_resp_q.push_back({tbl[i].expv[0], tbl[i].rdata});
      #1;
      chk($sformatf("vec%0d", i),
          {117'd0, inst_req_ready, data_req_ready, mem_req_valid, outstanding,
           mem_resp_ready, inst_resp_valid, data_resp_valid},
          {117'd0, tbl[i].expv});
      step();
    end

    // Request register held by mem_req_ready=0, then drained with a same-cycle reload.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    exp_req_q.push_back(FETCH_REQ);
    #1;
    chk("stall_load", {126'd0, inst_req_ready, data_req_ready}, {126'd0, 2'b10});
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      #1;
      chk($sformatf("stall_hold%0d", k),
          {60'd0, inst_req_ready, data_req_ready, mem_req_valid, mem_req},
          {60'd0, 1'b0, 1'b0, 1'b1, FETCH_REQ});
      step();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    exp_req_q.push_back({1'b0, 32'h0000_0200, 32'h0000_0055});
    #1;
    chk("stall_release", {126'd0, inst_req_ready, data_req_ready}, {126'd0, 2'b01});
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    step();

    // Response back-pressure from the data side while the data tag is at the head.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA1);
    exp_resp_q.push_back({1'b0, 32'hA1});
    #1;
    chk("bp_inst_first", {126'd0, inst_resp_valid, data_resp_valid}, {126'd0, 2'b10});
    step();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hB2);
      #1;
      chk($sformatf("bp_hold%0d", k),
          {120'd0, mem_resp_ready, inst_resp_valid, data_resp_valid, outstanding},
          {120'd0, 1'b0, 1'b0, 1'b1, 5'd1});
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hB2);
    exp_resp_q.push_back({1'b1, 32'hB2});
    #1;
    chk("bp_release", {126'd0, mem_resp_ready, data_resp_valid}, {126'd0, 2'b11});
    step();

    // Orphan response with nothing outstanding.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h77);
    #1;
    chk("orphan_accept", {124'd0, mem_resp_ready, inst_resp_valid, data_resp_valid, err_orphan_resp},
        {124'd0, 4'b1000});
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    #1;
    chk("orphan_flag", {122'd0, err_orphan_resp, outstanding}, {122'd0, 1'b1, 5'd0});
    step();

    // Asynchronous reset with a request staged and a read outstanding.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    #1;
    chk("pre_reset", {122'd0, mem_req_valid, outstanding}, {122'd0, 1'b1, 5'd1});
    RST = 1'b1;
    #1;
    chk("mid_reset", {56'd0, mem_req_valid, outstanding, err_orphan_resp, inst_resp_valid,
                      data_resp_valid, mem_req},
        {56'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 65'd0});
    step();
    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h99);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    #1;
    chk("post_reset_orphan", {122'd0, err_orphan_resp, outstanding}, {122'd0, 1'b1, 5'd0});
    step();

    chk("req_queue_empty", 128'(exp_req_q.size()), 128'd0);
    chk("resp_queue_empty", 128'(exp_resp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
